r5fp_i2f_pipe: RTL and testbench
================================

# r5fp_i2f_pipe

Pipelined integer-to-float conversion unit with valid/ready handshakes on both sides, feeding the FPU result/writeback path. It accepts 32- or 64-bit signed or unsigned integers and produces an IEEE-754 value in the configured format, rounded per RISC-V `rnd`. It uses three register stages (prepare, normalize, round/pack), sustains one conversion per cycle, and stalls cleanly under downstream backpressure.

## Interface
- `EXP_W`, 8: exponent width; 11 selects FP64.
- `SIG_W`, 23: stored significand width; 52 for FP64.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand presented.
- `in_ready`  out  1  stage 1 can accept the operand this cycle.
- `a`  in  64  integer operand.
- `isSigned`  in  1  treat the operand as two's complement.
- `halfWidth`  in  1  use only `a[31:0]`; zero- or sign-extend it per `isSigned`.
- `rnd`  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 behave as RNE.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  consumer takes the result.
- `z`  out  EXP_W+SIG_W+1  result {sign, exp, sig}.
- `status`  out  5  {NV, DZ, OF, UF, NX}.

## Operation
- Stage 1 (prepare):
  - Extend the operand: halfWidth=1 gives `{32{isSigned & a[31]}, a[31:0]}`.
  - sign = isSigned & ext[63]; magnitude = sign ? −ext : ext, as 64-bit unsigned (−2^63 gives 0x8000_0000_0000_0000).
  - Register sign, magnitude, rnd, and zero = (magnitude==0).
- Stage 2 (normalize):
  - lzc = leading-zero count of magnitude (0..63).
  - norm = magnitude << lzc.
  - uexp = bias + 63 − lzc, with bias = 2^(EXP_W−1)−1.
- Stage 3 (round/pack):
  - mant = norm[62 -: SIG_W]; guard = next bit down; sticky = OR of all remaining lower bits.
  - inexact = guard|sticky.
  - Increment rules:
    - RNE: guard & (sticky | mant[0]).
    - RTZ: never.
    - RDN: sign & inexact.
    - RUP: !sign & inexact.
    - RMM: guard.
  - If the increment carries out of mant: mant=0, exp+1.
  - Zero input gives z = all zeros (+0 in every mode, signed or not); NX=0.
- `status`: NV, DZ, UF are always 0. OF is always 0, since 2^64 < max finite for EXP_W≥8. NX = inexact.

## Timing
- Latency: 3 cycles from an accepted input (`in_valid & in_ready`) to `out_valid`. Throughput is 1 per cycle.
- Stage k advances when its successor is empty or its successor is advancing.
  - Stage 3 empties when `out_valid & out_ready`.
  - `in_ready = !v1 | advance1`. This is combinational from `out_ready` through the valid chain; there is no combinational path from `a`.
- `z` and `status` hold stable while `out_valid & !out_ready`.
- Simultaneous accept and output in one cycle: both occur, and occupancy is unchanged.
- All stages full with `out_ready`=0: `in_ready`=0 and nothing is lost or duplicated. Order is always preserved.
- Reset values: `out_valid`=0, `z`=0, `status`=0, `in_ready`=1 on the first cycle after reset.
- Internal valids clear on reset. Conversions in flight during reset are discarded, with no output.
- Data registers load only on stage advance (no load when the stage is stalled).

## Configuration
- `R5FP_I2F_FLAGS_EN` defined: NX is computed and carried through stage 3; `status` is driven as specified.
- Undefined: the inexact logic and flag registers are removed, and `status` is tied to 5'b0. `z` is unaffected.

## Structure
- Package `r5fp_i2f_pkg` contains:
  - rounding-mode enum (RNE/RTZ/RDN/RUP/RMM);
  - status bit indices (NV=4 … NX=0);
  - packed structs for the stage-1 and stage-2 pipeline registers;
  - the bias function of EXP_W.
- Sub-module `r5fp_lzc64`: combinational 64-bit leading-zero counter, output 6 bits (valid when input ≠ 0), instantiated in stage 2.

## Test plan
FP32 (EXP_W=8, SIG_W=23):
- Unsigned a=1, RNE → z=0x3F800000, NX=0, `out_valid` exactly 3 cycles after acceptance.
- isSigned=1, halfWidth=1, a=0x0000_0000_FFFF_FFFF (−1) → 0xBF800000. Same with a=0x8000_0000 → 0xCF000000, NX=0.
- Unsigned a=0xFFFF_FFFF_FFFF_FFFF:
  - RNE → 0x5F800000, NX=1.
  - RTZ → 0x5F7FFFFF.
- a=0x0100_0001:
  - RNE → 0x4B800000 (tie to even).
  - RUP → 0x4B800001.
  - Signed a=−0x0100_0001 with RDN → 0xCB800001.
  - NX=1 in all three.
- a=0, with each rnd and each isSigned/halfWidth combination → 0x00000000, status=0.
- Backpressure:
  - Send 5 back-to-back operands with `out_ready`=0: `in_ready` drops after 3 are accepted.
  - Release `out_ready` → all 5 results arrive in order with no duplicates.
  - Assert `reset` mid-stream → `out_valid`=0 on the next cycle, and no stale result appears afterwards.

Source files
------------

// File: rtl/r5fp_i2f_pkg.sv
// Shared types for the integer-to-float pipeline: rounding modes, status
// bit positions, inter-stage register layouts and the exponent bias helper.
package r5fp_i2f_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    localparam int ST_NV = 4;
    localparam int ST_DZ = 3;
    localparam int ST_OF = 2;
    localparam int ST_UF = 1;
    localparam int ST_NX = 0;

    // Stage 1 -> 2: sign and unsigned magnitude of the extended operand.
    typedef struct packed {
        logic        sign;
        logic        zero;
        logic [2:0]  rnd;
        logic [63:0] mag;
    } s1_t;

    // Stage 2 -> 3: left-justified magnitude and its biased exponent.
    // uexp is wide enough for any EXP_W up to 15.
    typedef struct packed {
        logic        sign;
        logic        zero;
        logic [2:0]  rnd;
        logic [63:0] norm;
        logic [15:0] uexp;
    } s2_t;

    function automatic logic [15:0] bias_of(input int ew);
        return 16'((1 << (ew - 1)) - 1);
    endfunction

endpackage

// File: rtl/r5fp_i2f_pipe_lzc.sv
// Combinational 64-bit leading-zero counter (module r5fp_lzc64).
// The count is meaningful only for a non-zero input.
module r5fp_lzc64 (
    input  logic [63:0] a_i,
    output logic [5:0]  cnt_o
);

    // Scan upward so the highest set bit writes last and wins.
    always_comb begin
        cnt_o = 6'd0;
        for (int i = 0; i < 64; i++) begin
            if (a_i[i]) cnt_o = 6'(63 - i);
        end
    end

endmodule

// File: rtl/r5fp_i2f_pipe.sv
// Three-stage integer-to-float converter (prepare, normalize, round/pack)
// with valid/ready on both sides. Define R5FP_I2F_FLAGS_EN to compute the
// inexact flag; otherwise status is tied to zero.
module r5fp_i2f_pipe
    import r5fp_i2f_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int SIG_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [63:0]            a,
    input  logic                   isSigned,
    input  logic                   halfWidth,
    input  logic [2:0]             rnd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+SIG_W:0]   z,
    output logic [4:0]             status
);

    localparam int ZW = EXP_W + SIG_W + 1;

    logic [3:1]    vld_q;
    logic          en1, en2, en3;
    s1_t           s1_d, s1_q;
    s2_t           s2_d, s2_q;
    logic [ZW-1:0] z_d, z_q;

    // A stage may load when it is empty or its content moves on this cycle.
    assign en3       = !vld_q[3] | out_ready;
    assign en2       = !vld_q[2] | en3;
    assign en1       = !vld_q[1] | en2;
    assign in_ready  = en1;
    assign out_valid = vld_q[3];
    assign z         = z_q;

    // Stage 1: extend, take sign and magnitude.
    logic [63:0] ext;
    always_comb begin
        ext       = halfWidth ? {{32{isSigned & a[31]}}, a[31:0]} : a;
        s1_d.sign = isSigned & ext[63];
        s1_d.mag  = s1_d.sign ? -ext : ext;
        s1_d.zero = (s1_d.mag == 64'd0);
        s1_d.rnd  = rnd;
    end

    // Stage 2: left-justify the magnitude.
    logic [5:0] lzc;
    r5fp_lzc64 u_lzc (.a_i(s1_q.mag), .cnt_o(lzc));

    always_comb begin
        s2_d.sign = s1_q.sign;
        s2_d.zero = s1_q.zero;
        s2_d.rnd  = s1_q.rnd;
        s2_d.norm = s1_q.mag << lzc;
        s2_d.uexp = bias_of(EXP_W) + 16'd63 - {10'd0, lzc};
    end

    // Stage 3: round the bits below the kept significand and pack.
    logic [SIG_W-1:0] mant;
    logic             guard, sticky, inexact, inc;
    logic [SIG_W:0]   mant_r;
    logic [EXP_W-1:0] exp_r;
    always_comb begin
        mant    = s2_q.norm[62 -: SIG_W];
        guard   = s2_q.norm[62-SIG_W];
        sticky  = |(s2_q.norm << (SIG_W + 2));
        inexact = guard | sticky;
        case (s2_q.rnd)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = s2_q.sign & inexact;
            RM_RUP:  inc = !s2_q.sign & inexact;
            RM_RMM:  inc = guard;
            default: inc = guard & (sticky | mant[0]);
        endcase
        mant_r = {1'b0, mant} + (SIG_W+1)'(inc);
        // A carry out of the significand leaves it all-zero and bumps the exponent.
        exp_r  = s2_q.uexp[EXP_W-1:0] + EXP_W'(mant_r[SIG_W]);
        z_d    = s2_q.zero ? '0 : {s2_q.sign, exp_r, mant_r[SIG_W-1:0]};
    end

    // Valid chain; in-flight work is dropped on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            if (en1) vld_q[1] <= in_valid;
            if (en2) vld_q[2] <= vld_q[1];
            if (en3) vld_q[3] <= vld_q[2];
        end
    end

    // Data registers load only when a valid item advances into them.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            z_q  <= '0;
        end else begin
            if (en1 && in_valid) s1_q <= s1_d;
            if (en2 && vld_q[1]) s2_q <= s2_d;
            if (en3 && vld_q[2]) z_q  <= z_d;
        end
    end

`ifdef R5FP_I2F_FLAGS_EN
    logic nx_q;

    // Inexact flag travels alongside the packed result.
    always_ff @(posedge clk) begin
        if (reset)                 nx_q <= 1'b0;
        else if (en3 && vld_q[2])  nx_q <= inexact & !s2_q.zero;
    end

    always_comb begin
        status        = 5'b0;
        status[ST_NX] = nx_q;
    end

    logic unused_bits;
    assign unused_bits = ^{s2_q.norm[63], s2_q.uexp[15:EXP_W]};
`else
    assign status = 5'b0;

    logic unused_bits;
    assign unused_bits = ^{s2_q.norm[63], s2_q.uexp[15:EXP_W], inexact};
`endif

endmodule

// File: tb/tb_r5fp_i2f_pipe.sv
// Self-checking bench for r5fp_i2f_pipe (FP32 build): directed vectors,
// backpressure, mid-stream reset and randomized traffic against a model.
module tb_r5fp_i2f_pipe;

    localparam int EXP_W = 8;
    localparam int SIG_W = 23;
    localparam int ZW    = EXP_W + SIG_W + 1;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   a;
    logic          isSigned;
    logic          halfWidth;
    logic [2:0]    rnd;
    logic          out_valid;
    logic          out_ready;
    logic [ZW-1:0] z;
    logic [4:0]    status;

    r5fp_i2f_pipe #(.EXP_W(EXP_W), .SIG_W(SIG_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .isSigned(isSigned), .halfWidth(halfWidth), .rnd(rnd),
        .out_valid(out_valid), .out_ready(out_ready), .z(z), .status(status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] z;
        logic [4:0]  st;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        dir_use = 1'b0;
    logic [63:0] dir_z   = '0;
    logic        dir_nx  = 1'b0;
    logic        held_v  = 1'b0;
    logic [63:0] held_z  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    function automatic logic [4:0] st_of(input logic nx);
`ifdef R5FP_I2F_FLAGS_EN
        return {4'b0, nx};
`else
        return 5'b0 & {4'b0, nx};
`endif
    endfunction

    // Value-level model: exact integer, then quotient/remainder rounding.
    function automatic logic [63:0] ref_z(input logic [63:0] av, input logic s,
                                          input logic h, input logic [2:0] r,
                                          output logic nx);
        logic [63:0]   ext, mag, q, rem, half;
        logic [ZW-1:0] zz;
        logic          sg, inc;
        int            e, sh;
        ext = h ? (s ? {{32{av[31]}}, av[31:0]} : {32'b0, av[31:0]}) : av;
        sg  = s && ext[63];
        mag = sg ? (~ext + 64'd1) : ext;
        nx  = 1'b0;
        if (mag == 64'd0) return 64'd0;
        e = 63;
        while (!mag[e]) e--;
        if (e <= SIG_W) begin
            q = mag << (SIG_W - e);
        end else begin
            sh   = e - SIG_W;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 64'd1 << (sh - 1);
            nx   = (rem != 64'd0);
            case (r)
                3'd1:    inc = 1'b0;
                3'd2:    inc = sg && nx;
                3'd3:    inc = !sg && nx;
                3'd4:    inc = (rem >= half);
                default: inc = (rem > half) || (rem == half && q[0]);
            endcase
            q = q + 64'(inc);
            if (q[SIG_W+1]) begin
                q = q >> 1;
                e++;
            end
        end
        zz = {sg, EXP_W'(BIAS + e), q[SIG_W-1:0]};
        return 64'(zz);
    endfunction

    // Monitor: scoreboard push on accept, pop and compare on output.
    always @(negedge clk) begin
        exp_t        ex;
        logic        nx;
        if (reset) begin
            sb.delete();
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid) chk("hold_z", 64'(z), held_z);
            held_v = out_valid && !out_ready;
            held_z = 64'(z);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 64'd1, 64'd0);
                end else begin
                    ex = sb.pop_front();
                    chk("z", 64'(z), ex.z);
                    chk("status", 64'(status), 64'(ex.st));
                end
            end
            if (in_valid && in_ready) begin
                if (dir_use) begin
                    ex.z  = dir_z;
                    ex.st = st_of(dir_nx);
                end else begin
                    ex.z  = ref_z(a, isSigned, halfWidth, rnd, nx);
                    ex.st = st_of(nx);
                end
                sb.push_back(ex);
            end
        end
    end

    // Present one operand and hold it until accepted (bounded).
    task automatic send(input logic [63:0] av, input logic s, input logic h,
                        input logic [2:0] r);
        logic acc;
        int   n;
        a = av; isSigned = s; halfWidth = h; rnd = r; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic dsend(input logic [63:0] av, input logic s, input logic h,
                         input logic [2:0] r, input logic [31:0] ez, input logic enx);
        dir_use = 1'b1; dir_z = 64'(ez); dir_nx = enx;
        send(av, s, h, r);
        in_valid = 1'b0;
        dir_use  = 1'b0;
    endtask

    initial begin
        int          t0, k, sent, lat;
        logic        acc;
        logic [63:0] ops[5];

        reset = 1'b1; in_valid = 1'b0; a = '0; isSigned = 1'b0;
        halfWidth = 1'b0; rnd = 3'd0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_z", 64'(z), 64'd0);
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Latency of a lone conversion into an empty pipe.
        dir_use = 1'b1; dir_z = 64'h3F800000; dir_nx = 1'b0;
        a = 64'd1; isSigned = 1'b0; halfWidth = 1'b0; rnd = 3'd0; in_valid = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0; dir_use = 1'b0;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                lat = cyc - t0;
                break;
            end
            @(posedge clk); #1;
        end
        chk("latency", 64'(lat), 64'd3);
        drain();

        // Directed FP32 vectors.
        dsend(64'h0000_0000_FFFF_FFFF, 1, 1, 3'd0, 32'hBF800000, 0);
        dsend(64'h0000_0000_8000_0000, 1, 1, 3'd0, 32'hCF000000, 0);
        dsend(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 3'd0, 32'h5F800000, 1);
        dsend(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 3'd1, 32'h5F7FFFFF, 1);
        dsend(64'h0000_0000_0100_0001, 0, 0, 3'd0, 32'h4B800000, 1);
        dsend(64'h0000_0000_0100_0001, 0, 0, 3'd3, 32'h4B800001, 1);
        dsend(64'hFFFF_FFFF_FEFF_FFFF, 1, 0, 3'd2, 32'hCB800001, 1);
        for (int r = 0; r < 8; r++)
            for (int m = 0; m < 4; m++)
                dsend(64'd0, m[0], m[1], 3'(r), 32'h0, 0);
        drain();

        // Backpressure: three fill the pipe, then in_ready must stay low.
        for (int i = 0; i < 5; i++) ops[i] = {$urandom, $urandom} >> $urandom_range(0, 40);
        out_ready = 1'b0;
        k = 0;
        a = ops[0]; isSigned = 1'b1; halfWidth = 1'b0; rnd = 3'd0; in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k < 5) a = ops[k];
            end
        end
        chk("bp_accepted", 64'(k), 64'd3);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && k < 5; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k < 5) a = ops[k];
            end
        end
        chk("bp_all_sent", 64'(k), 64'd5);
        drain();

        // Reset with conversions in flight.
        send(64'd1234, 0, 0, 3'd0);
        send(64'd5678, 0, 0, 3'd1);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_quiet", 64'(out_valid), 64'd0);

        // Randomized traffic with random backpressure.
        sent = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 4000 && sent < 300; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            if (!in_valid || acc) begin
                if (sent < 300 && $urandom_range(0, 3) != 0) begin
                    a = {$urandom, $urandom} >> $urandom_range(0, 63);
                    if ($urandom_range(0, 3) == 0) a = ~a;
                    isSigned = 1'($urandom);
                    halfWidth = 1'($urandom);
                    rnd = 3'($urandom_range(0, 7));
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        chk("rand_sent", 64'(sent), 64'd300);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
